// File: rtl/clock_pkg.sv
// Shared field widths, limits and helpers for the clock timekeeper.
package clock_pkg;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HRS_W = 4;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HRS_W-1:0] HRS_MAX = 4'd11;
  localparam logic [MIN_W-1:0] AL_STEP = 6'd10;

  localparam int unsigned SNOOZE_S_DEFAULT = 300;

  // Adds 0..2 with wrap at lim, using equality tests only so no field is ever range-compared.
  function automatic logic [5:0] wrap_add(input logic [5:0] val, input logic [1:0] inc,
                                          input logic [5:0] lim);
    logic [5:0] res;
    res = val + 6'(inc);
    if (inc == 2'd1 && val == lim) res = '0;
    if (inc == 2'd2 && val == lim) res = 6'd1;
    if (inc == 2'd2 && val == lim - 6'd1) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the video clock down to a one-cycle second pulse and a half-second flag.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 31_500_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic half
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  // tick/half are registered copies of the count decode, so they read 0 while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick    <= 1'b0;
      half    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick    <= (count_q == LAST);
      half    <= (count_q < HALF);
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour clock with alarm; optional snooze enabled by defining CLOCK_TIMEKEEPER_SNOOZE_EN.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 31_500_000,
  parameter int unsigned SNOOZE_S = SNOOZE_S_DEFAULT
) (
  input  logic             video_clk,
  input  logic             reset,
  input  logic             sec_inc,
  input  logic             min_inc,
  input  logic             hrs_inc,
  input  logic             al_inc,
  input  logic             al_toggle,
  input  logic             snooze,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HRS_W-1:0] hours,
  output logic [MIN_W-1:0] al_minutes,
  output logic [HRS_W-1:0] al_hours,
  output logic             al_on,
  output logic             alarm,
  output logic             sec_tick,
  output logic             half_sec
);

  localparam logic [MIN_W-1:0] AL_LAST = MIN_MAX + 6'd1 - AL_STEP;

  logic [SEC_W-1:0] sec_d;
  logic [MIN_W-1:0] min_d, al_min_d;
  logic [HRS_W-1:0] hrs_d, al_hrs_d;
  logic             carry_min, carry_hrs, al_wrap, match, al_off;
  logic             al_on_d, alarm_d;
  logic             snz_hit, snz_expire;

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk  (video_clk),
    .reset(reset),
    .tick (sec_tick),
    .half (half_sec)
  );

`ifdef CLOCK_TIMEKEEPER_SNOOZE_EN
  localparam int unsigned SW = $clog2(SNOOZE_S + 1);
  logic [SW-1:0] snz_q, snz_d;

  // A reload on snooze wins over the per-second decrement; arming off cancels everything.
  always_comb begin
    snz_d      = snz_q;
    snz_expire = 1'b0;
    snz_hit    = snooze && alarm;
    if (sec_tick && snz_q != '0) begin
      snz_d      = snz_q - SW'(1);
      snz_expire = (snz_q == SW'(1)) && al_on;
    end
    if (snz_hit) snz_d = SW'(SNOOZE_S);
    if (al_off) snz_d = '0;
  end

  always_ff @(posedge video_clk) begin
    if (reset) snz_q <= '0;
    else       snz_q <= snz_d;
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snz_hit       = 1'b0;
  assign snz_expire    = 1'b0;
`endif

  always_comb begin
    carry_min = sec_tick && (seconds == SEC_MAX);
    carry_hrs = carry_min && (minutes == MIN_MAX);
    sec_d = SEC_W'(wrap_add(seconds, {1'b0, sec_tick} + {1'b0, sec_inc}, SEC_MAX));
    min_d = MIN_W'(wrap_add(minutes, {1'b0, carry_min} + {1'b0, min_inc}, MIN_MAX));
    hrs_d = HRS_W'(wrap_add(6'(hours), {1'b0, carry_hrs} + {1'b0, hrs_inc}, 6'(HRS_MAX)));

    al_wrap  = al_inc && (al_minutes == AL_LAST);
    al_min_d = al_minutes;
    if (al_inc) al_min_d = al_wrap ? '0 : al_minutes + AL_STEP;
    al_hrs_d = HRS_W'(wrap_add(6'(al_hours), {1'b0, al_wrap}, 6'(HRS_MAX)));

    match   = al_on && (hours == al_hours) && (minutes == al_minutes) && (seconds == '0);
    al_off  = al_toggle && al_on;
    al_on_d = al_on ^ al_toggle;

    alarm_d = alarm;
    if (match || snz_expire) alarm_d = 1'b1;
    if (snz_hit)             alarm_d = 1'b0;
    if (al_off)              alarm_d = 1'b0;
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      seconds    <= '0;
      minutes    <= '0;
      hours      <= '0;
      al_minutes <= '0;
      al_hours   <= '0;
      al_on      <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      seconds    <= sec_d;
      minutes    <= min_d;
      hours      <= hrs_d;
      al_minutes <= al_min_d;
      al_hours   <= al_hrs_d;
      al_on      <= al_on_d;
      alarm      <= alarm_d;
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Randomized and directed bench for clock_timekeeper against a behavioural time model.
module tb_clock_timekeeper;

  localparam int HZ  = 10;
  localparam int SNZ = 3;

  logic       video_clk, reset;
  logic       sec_inc, min_inc, hrs_inc, al_inc, al_toggle, snooze;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm, sec_tick, half_sec;

  int n_checks = 0;
  int n_bad    = 0;

  // Model state: cycles since release, clock fields, alarm time in minutes-of-12h.
  int m_k, m_sec, m_min, m_hr, m_al, m_snz;
  bit m_alon, m_alarm;

  clock_timekeeper #(
    .CLK_HZ  (HZ),
    .SNOOZE_S(SNZ)
  ) dut (
    .video_clk (video_clk),
    .reset     (reset),
    .sec_inc   (sec_inc),
    .min_inc   (min_inc),
    .hrs_inc   (hrs_inc),
    .al_inc    (al_inc),
    .al_toggle (al_toggle),
    .snooze    (snooze),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .al_minutes(al_minutes),
    .al_hours  (al_hours),
    .al_on     (al_on),
    .alarm     (alarm),
    .sec_tick  (sec_tick),
    .half_sec  (half_sec)
  );

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit m_tick();
    return (m_k > 0) && (m_k % HZ == 0);
  endfunction

  function automatic bit m_half();
    return (m_k > 0) && ((m_k - 1) % HZ < HZ / 2);
  endfunction

  task automatic model_next();
    int t, c1, c2, nal, nsnz;
    bit nalarm, expire, hit;
    if (reset) begin
      m_k = 0; m_sec = 0; m_min = 0; m_hr = 0; m_al = 0; m_snz = 0;
      m_alon = 0; m_alarm = 0;
      return;
    end
    t  = int'(m_tick());
    c1 = (t == 1 && m_sec == 59) ? 1 : 0;
    c2 = (c1 == 1 && m_min == 59) ? 1 : 0;
    nal = al_inc ? (m_al + 10) % 720 : m_al;
    nalarm = m_alarm;
    nsnz = m_snz;
    expire = 0;
    hit = 0;
`ifdef CLOCK_TIMEKEEPER_SNOOZE_EN
    if (t == 1 && m_snz > 0) begin
      nsnz = m_snz - 1;
      expire = (nsnz == 0) && m_alon;
    end
    hit = snooze && m_alarm;
    if (hit) nsnz = SNZ;
`endif
    if ((m_alon && m_hr == m_al / 60 && m_min == m_al % 60 && m_sec == 0) || expire) nalarm = 1;
    if (hit) nalarm = 0;
    if (al_toggle && m_alon) begin
      nalarm = 0;
      nsnz = 0;
    end
    m_sec   = (m_sec + t + int'(sec_inc)) % 60;
    m_min   = (m_min + c1 + int'(min_inc)) % 60;
    m_hr    = (m_hr + c2 + int'(hrs_inc)) % 12;
    m_al    = nal;
    m_alarm = nalarm;
    m_snz   = nsnz;
    m_alon  = m_alon ^ al_toggle;
    m_k++;
  endtask

  task automatic step();
    model_next();
    @(posedge video_clk);
    #1;
    {sec_inc, min_inc, hrs_inc, al_inc, al_toggle, snooze} = '0;
    check_val("seconds", 32'(seconds), 32'(m_sec));
    check_val("minutes", 32'(minutes), 32'(m_min));
    check_val("hours", 32'(hours), 32'(m_hr));
    check_val("al_minutes", 32'(al_minutes), 32'(m_al % 60));
    check_val("al_hours", 32'(al_hours), 32'(m_al / 60));
    check_val("al_on", 32'(al_on), 32'(m_alon));
    check_val("alarm", 32'(alarm), 32'(m_alarm));
    check_val("sec_tick", 32'(sec_tick), 32'(m_tick()));
    check_val("half_sec", 32'(half_sec), 32'(m_half()));
  endtask

  // Stops just before a tick cycle in which the clock shows hh:mm:ss.
  task automatic preset(input int hh, input int mm, input int ss);
    for (int i = 0; i < 3000; i++) begin
      if (m_tick() && m_hr == hh && m_min == mm && m_sec == ss) return;
      if (!m_tick()) begin
        sec_inc = (m_sec != ss);
        min_inc = (m_min != mm);
        hrs_inc = (m_hr != hh);
      end
      step();
    end
    check_val("preset_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int al_m_exp[6];
    int ticks;
    bit seen;
    al_m_exp = '{10, 20, 30, 40, 50, 0};
    {sec_inc, min_inc, hrs_inc, al_inc, al_toggle, snooze} = '0;
    m_k = 0; m_sec = 0; m_min = 0; m_hr = 0; m_al = 0; m_snz = 0; m_alon = 0; m_alarm = 0;

    // Reset ignores adjust pulses.
    reset = 1'b1;
    {sec_inc, min_inc, hrs_inc, al_inc, al_toggle, snooze} = '1;
    step();
    check_val("rst_seconds", 32'(seconds), 0);
    check_val("rst_half", 32'(half_sec), 0);
    check_val("rst_al_on", 32'(al_on), 0);
    reset = 1'b0;

    // Tick on cycles 10 and 20 after release; half_sec over the first five cycles of each second.
    for (int c = 1; c <= 20; c++) begin
      step();
      check_val("tick_cycle", 32'(sec_tick), 32'((c % HZ) == 0));
      check_val("half_cycle", 32'(half_sec), 32'(((c - 1) % HZ) < HZ / 2));
      if (c == 11) check_val("first_second", 32'(seconds), 1);
    end

    preset(11, 59, 59);
    step();
    check_val("roll_all", 32'({hours, minutes, seconds}), 0);

    preset(2, 10, 59);
    sec_inc = 1'b1;
    step();
    check_val("co59_sec", 32'(seconds), 1);
    check_val("co59_min", 32'(minutes), 11);
    preset(2, 20, 58);
    sec_inc = 1'b1;
    step();
    check_val("co58_sec", 32'(seconds), 0);
    check_val("co58_min", 32'(minutes), 20);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      al_inc = 1'b1;
      step();
      check_val("al_step_min", 32'(al_minutes), 32'(al_m_exp[i]));
      check_val("al_step_hrs", 32'(al_hours), 32'(i == 5));
    end

    preset(0, 59, 59);
    al_toggle = 1'b1;
    step();
    check_val("ring_time", 32'({hours, minutes, seconds}), 32'({4'd1, 6'd0, 6'd0}));
    check_val("ring_armed", 32'(al_on), 1);
    check_val("ring_early", 32'(alarm), 0);
    step();
    check_val("ring_set", 32'(alarm), 1);
    al_toggle = 1'b1;
    step();
    check_val("off_alarm", 32'(alarm), 0);
    check_val("off_al_on", 32'(al_on), 0);
    al_toggle = 1'b1;
    step();
    al_toggle = 1'b1;
    step();
    check_val("tog_match_alarm", 32'(alarm), 0);
    check_val("tog_match_al_on", 32'(al_on), 0);

`ifdef CLOCK_TIMEKEEPER_SNOOZE_EN
    al_toggle = 1'b1;
    step();
    step();
    check_val("snz_ring", 32'(alarm), 1);
    for (int i = 0; i < 30 && m_sec == 0; i++) step();
    snooze = 1'b1;
    step();
    check_val("snz_clear", 32'(alarm), 0);
    ticks = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (sec_tick) ticks++;
      step();
      seen = alarm;
    end
    check_val("snz_reset", 32'(seen), 1);
    check_val("snz_ticks", 32'(ticks), SNZ);
    snooze = 1'b1;
    step();
    check_val("snz2_clear", 32'(alarm), 0);
    al_toggle = 1'b1;
    step();
    seen = 0;
    for (int i = 0; i < 6 * HZ; i++) begin
      step();
      if (alarm) seen = 1;
    end
    check_val("snz_cancel", 32'(seen), 0);
`endif

    // Random adjust traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      sec_inc   = ($urandom_range(0, 7) == 0);
      min_inc   = ($urandom_range(0, 7) == 0);
      hrs_inc   = ($urandom_range(0, 7) == 0);
      al_inc    = ($urandom_range(0, 7) == 0);
      al_toggle = ($urandom_range(0, 15) == 0);
      snooze    = ($urandom_range(0, 7) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
